instr_fetch_unit: RTL



---
 rtl/instr_fetch_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads the 1-cycle synchronous ROM,
// and hands words to decode over valid/ready with a one-entry skid.
//
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   iram_addr / iram_q    ROM address (the fetch PC) and ROM data
//   instr, instr_pc       registered instruction and its address
//   instr_valid/ready     handshake toward decode
//   redirect, redirect_pc single-cycle request to load a new PC
//   halted                fetch stopped after a halt word
module instr_fetch_unit #(
  parameter int              ADDR_W   = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HALT_OP  = 4'b1111
) (
  input  logic               clock,
  input  logic               reset,
  output logic [ADDR_W-1:0]  iram_addr,
  input  logic [INSTR_W-1:0] iram_q,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted
);

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  fetch_pc_q;
  logic [ADDR_W-1:0]  fetch_pc_d;
  logic               pend_q;
  logic [ADDR_W-1:0]  pend_pc_q;
  logic               skid_valid_q;
  logic [INSTR_W-1:0] skid_instr_q;
  logic [ADDR_W-1:0]  skid_pc_q;
  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  instr_pc_q;

  logic out_free;
  logic is_halt;
  logic advance;

  assign out_free = !valid_q || instr_ready;
  assign is_halt  = (iram_q[INSTR_W-1 -: 4] == HALT_OP);

  // Stop issuing when the pending word has nowhere to go, when the
  // skid is occupied, or when the pending word is a halt.
  assign advance = (state_q == S_RUN) && !redirect
                && !skid_valid_q
                && !(pend_q && !out_free)
                && !(pend_q && is_halt);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect)
      fetch_pc_d = redirect_pc;
    else if (advance)
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_RUN;
      fetch_pc_q   <= RESET_PC;
      pend_q       <= 1'b0;
      pend_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      instr_pc_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      if (redirect) begin
        // In-flight and buffered words belong to the old stream.
        pend_q       <= 1'b0;
        skid_valid_q <= 1'b0;
        valid_q      <= 1'b0;
        state_q      <= S_RUN;
      end else begin
        pend_q <= advance;
        if (advance)
          pend_pc_q <= fetch_pc_q;

        if (skid_valid_q && out_free) begin
          instr_q      <= skid_instr_q;
          instr_pc_q   <= skid_pc_q;
          valid_q      <= 1'b1;
          skid_valid_q <= 1'b0;
        end else if (pend_q && out_free) begin
          instr_q    <= iram_q;
          instr_pc_q <= pend_pc_q;
          valid_q    <= 1'b1;
        end else if (pend_q) begin
          // Output is stalled: park the word that the ROM already returned.
          skid_instr_q <= iram_q;
          skid_pc_q    <= pend_pc_q;
          skid_valid_q <= 1'b1;
        end else if (instr_ready && valid_q) begin
          valid_q <= 1'b0;
        end

        if (pend_q && is_halt)
          state_q <= S_HALT;
      end
    end
  end

  assign iram_addr   = fetch_pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == S_HALT);

endmodule
